// File: rtl/exe_mdu_stage.sv
// ============================================================================
// exe_mdu_stage : execute stage, EX/MEM register, multiply/divide unit, HI/LO.
// Build option EXE_MUL_PIPE_EN registers the multiplier.   Revision 1.0
// ============================================================================
`default_nettype none

module exe_mdu_stage #(
   parameter int XLEN   = 32,
   parameter int MMOP_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_flush_i,
   input  logic              ex_stall_i,
   input  logic [31:0]       ex_inst_i,
   input  logic              ex_inslot_i,
   input  logic [XLEN-1:0]   ex_opr1_i,
   input  logic [XLEN-1:0]   ex_opr2_i,
   input  logic [XLEN-1:0]   ex_alures_i,
   input  logic              ex_wren_i,
   input  logic [4:0]        ex_waddr_i,
   input  logic              ex_nofwd_i,
   input  logic [MMOP_W-1:0] ex_memop_i,
   input  logic [3:0]        ex_mduop_i,
   output logic              ex_wren_o,
   output logic [4:0]        ex_waddr_o,
   output logic [XLEN-1:0]   ex_wdata_o,
   output logic [31:0]       ex_inst_o,
   output logic              ex_inslot_o,
   output logic              ex_nofwd_o,
   output logic [MMOP_W-1:0] ex_memop_o,
   output logic [XLEN-1:0]   ex_hi_o,
   output logic [XLEN-1:0]   ex_lo_o,
   output logic              ex_stallreq_o,
   output logic [XLEN-1:0]   ex_wdata_bp_o
);

   localparam int CNT_W = $clog2(XLEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MFHI  = 4'd7;
   localparam logic [3:0] OP_MFLO  = 4'd8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } div_state_t;

   div_state_t state, state_next;

   logic            en;
   logic            wr_ok;
   logic            is_mul;
   logic            is_div;
   logic            div_signed;
   logic [XLEN-1:0] hi, lo;
   logic [XLEN-1:0] wdata_next;

   assign en         = ~ex_stall_i;
   assign wr_ok      = en & ~ex_flush_i;
   assign is_mul     = (ex_mduop_i == OP_MULT) | (ex_mduop_i == OP_MULTU);
   assign is_div     = (ex_mduop_i == OP_DIV)  | (ex_mduop_i == OP_DIVU);
   assign div_signed = (ex_mduop_i == OP_DIV);

   // Low 2*XLEN bits of the product of the sign/zero-extended operands are
   // exact for both the signed and unsigned forms.
   logic [2*XLEN-1:0] mul_a, mul_b, mul_prod;
   logic              mul_sext;

   assign mul_sext = (ex_mduop_i == OP_MULT);
   assign mul_a    = {{XLEN{mul_sext & ex_opr1_i[XLEN-1]}}, ex_opr1_i};
   assign mul_b    = {{XLEN{mul_sext & ex_opr2_i[XLEN-1]}}, ex_opr2_i};
   assign mul_prod = mul_a * mul_b;

   logic              mul_stall;
   logic              mul_wr;
   logic [2*XLEN-1:0] mul_res;

`ifdef EXE_MUL_PIPE_EN
   logic              mul_phase;
   logic [2*XLEN-1:0] mul_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mul_phase <= 1'b0;
         mul_q     <= '0;
      end else if (ex_flush_i) begin
         mul_phase <= 1'b0;
      end else if (!mul_phase && is_mul) begin
         mul_q     <= mul_prod;
         mul_phase <= 1'b1;
      end else if (mul_phase && en) begin
         mul_phase <= 1'b0;
      end
   end

   assign mul_stall = is_mul & ~mul_phase & ~ex_flush_i;
   assign mul_wr    = mul_phase & wr_ok;
   assign mul_res   = mul_q;
`else
   assign mul_stall = 1'b0;
   assign mul_wr    = is_mul & wr_ok;
   assign mul_res   = mul_prod;
`endif

   // Divider operands are latched as magnitudes; signs are reapplied on retire.
   logic            sign1, sign2;
   logic [XLEN-1:0] abs1, abs2;

   assign sign1 = div_signed & ex_opr1_i[XLEN-1];
   assign sign2 = div_signed & ex_opr2_i[XLEN-1];
   assign abs1  = sign1 ? (~ex_opr1_i + 1'b1) : ex_opr1_i;
   assign abs2  = sign2 ? (~ex_opr2_i + 1'b1) : ex_opr2_i;

   logic [CNT_W-1:0] cnt;
   logic [XLEN-1:0]  quo, rem, dsor;
   logic             neg_q, neg_r, dzero;
   logic [XLEN:0]    trial;
   logic [XLEN-1:0]  div_lo, div_hi;

   assign trial  = {rem, quo[XLEN-1]} - {1'b0, dsor};
   assign div_lo = dzero ? '1 : (neg_q ? (~quo + 1'b1) : quo);
   assign div_hi = neg_r ? (~rem + 1'b1) : rem;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (is_div) state_next = BUSY;
         BUSY:    if (cnt == CNT_LAST) state_next = DONE;
         DONE:    if (en) state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (ex_flush_i) state_next = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         quo   <= '0;
         rem   <= '0;
         dsor  <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         dzero <= 1'b0;
      end else if (ex_flush_i) begin
         cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (is_div) begin
                  quo   <= abs1;
                  rem   <= '0;
                  dsor  <= abs2;
                  neg_q <= sign1 ^ sign2;
                  neg_r <= sign1;
                  dzero <= (ex_opr2_i == '0);
                  cnt   <= '0;
               end
            end
            BUSY: begin
               cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
               if (!trial[XLEN]) begin
                  rem <= trial[XLEN-1:0];
                  quo <= {quo[XLEN-2:0], 1'b1};
               end else begin
                  rem <= {rem[XLEN-2:0], quo[XLEN-1]};
                  quo <= {quo[XLEN-2:0], 1'b0};
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi <= '0;
         lo <= '0;
      end else if (wr_ok) begin
         if (state == DONE) begin
            hi <= div_hi;
            lo <= div_lo;
         end else if (mul_wr) begin
            hi <= mul_res[2*XLEN-1:XLEN];
            lo <= mul_res[XLEN-1:0];
         end else if (ex_mduop_i == OP_MTHI) begin
            hi <= ex_opr1_i;
         end else if (ex_mduop_i == OP_MTLO) begin
            lo <= ex_opr1_i;
         end
      end
   end

   always_comb begin
      wdata_next = ex_alures_i;
      if (ex_mduop_i == OP_MFHI) wdata_next = hi;
      else if (ex_mduop_i == OP_MFLO) wdata_next = lo;
   end

   // A flush inserts a bubble even while the stage is stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_wren_o   <= 1'b0;
         ex_waddr_o  <= '0;
         ex_wdata_o  <= '0;
         ex_inst_o   <= '0;
         ex_inslot_o <= 1'b0;
         ex_nofwd_o  <= 1'b0;
         ex_memop_o  <= '0;
      end else if (ex_flush_i) begin
         ex_wren_o   <= 1'b0;
         ex_waddr_o  <= '0;
         ex_wdata_o  <= '0;
         ex_inst_o   <= '0;
         ex_inslot_o <= 1'b0;
         ex_nofwd_o  <= 1'b0;
         ex_memop_o  <= '0;
      end else if (en) begin
         ex_wren_o   <= ex_wren_i;
         ex_waddr_o  <= ex_waddr_i;
         ex_wdata_o  <= wdata_next;
         ex_inst_o   <= ex_inst_i;
         ex_inslot_o <= ex_inslot_i;
         ex_nofwd_o  <= ex_nofwd_i;
         ex_memop_o  <= ex_memop_i;
      end
   end

   assign ex_hi_o       = hi;
   assign ex_lo_o       = lo;
   assign ex_wdata_bp_o = wdata_next;
   assign ex_stallreq_o = ((state == IDLE) & is_div & ~ex_flush_i)
                        | (state == BUSY)
                        | mul_stall;

endmodule

`default_nettype wire

// File: doc/exe_mdu_stage.md
# exe_mdu_stage

Parametrised execute stage with an integrated multiply/divide unit and architectural HI/LO registers. It sits between decode/issue and memory. It registers ALU results into the EX/MEM pipeline register, executes MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO, and raises a stall request while a multi-cycle operation is in flight. Flush from the controller aborts any operation in progress.

## Interface
- XLEN, 32, datapath width; even, ≥8
- MMOP_W, 5, memop field width
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ex_flush_i  in  1  controller flush; priority over stall
- ex_stall_i  in  1  controller stall; controller ORs in ex_stallreq_o
- ex_inst_i  in  32  instruction word
- ex_inslot_i  in  1  in delay slot
- ex_opr1_i, ex_opr2_i  in  XLEN  operands (rs, rt)
- ex_alures_i  in  XLEN  ALU result
- ex_wren_i  in  1  GPR write enable
- ex_waddr_i  in  5  GPR write address
- ex_nofwd_i  in  1  no-forward flag
- ex_memop_i  in  MMOP_W  memory op
- ex_mduop_i  in  4  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO, others none
- ex_wren_o, ex_waddr_o, ex_wdata_o, ex_inst_o, ex_inslot_o, ex_nofwd_o, ex_memop_o  out  as inputs  EX/MEM register
- ex_hi_o, ex_lo_o  out  XLEN  architectural HI/LO
- ex_stallreq_o  out  1  stall request
- ex_wdata_bp_o  out  XLEN  combinational bypass of next-cycle wdata

## Operation
- en = ~ex_stall_i. EX/MEM register loads on en. On ex_flush_i it loads zero (a bubble) regardless of stall.
- wdata_next: HI for MFHI, LO for MFLO, ex_alures_i otherwise. ex_wdata_bp_o = wdata_next.
- HI/LO write happens only on a clock edge where en=1 and flush=0.
- MTHI: HI←opr1. MTLO: LO←opr1.
- MULT/MULTU: 2·XLEN-bit product, signed or unsigned. {HI,LO}←product.
- Divider FSM states:
  - IDLE: on DIV/DIVU with no flush, latch the absolute values and signs, set cnt=0, go to BUSY.
  - BUSY: one restoring-division bit per cycle. Go to DONE when cnt=XLEN-1.
  - DONE: hold the result. On en, write HI/LO and go to IDLE.
- Divider results:
  - Quotient is negated if sign1^sign2 (signed only).
  - Remainder takes the dividend's sign.
  - LO=quotient, HI=remainder.
  - Divide by zero: LO=all ones, HI=opr1. The full XLEN cycles still run.
- ex_stallreq_o = (IDLE & div op & ~flush) | BUSY | mul-pipe stall (see Configuration).
- Flush in any state: FSM→IDLE, cnt←0, no HI/LO write.
- Stall in BUSY has no effect; the iteration continues.
- Stall in DONE holds the result indefinitely.

## Timing
- Reset values: every output is 0, HI=LO=0, FSM=IDLE, cnt=0. Reset asserted mid-division aborts it; no HI/LO change survives.
- ALU and MT/MF ops: 1 cycle. Output is valid after the first edge with en.
- DIV accepted in cycle 0 (IDLE). BUSY runs cycles 1..XLEN. DONE is cycle XLEN+1, with stallreq=0.
- ex_stallreq_o is high for XLEN+1 cycles. HI/LO and EX/MEM update at the end of cycle XLEN+1 if en.
- An MFHI/MFLO in EX the cycle after MULT/DIV retires reads the new value; no hazard.
- Back-to-back DIVs: the second is accepted from IDLE the cycle after the first retires.

## Configuration
- EXE_MUL_PIPE_EN defined: multiply is registered.
  - Cycle 0 latches the product into an internal register and holds ex_stallreq_o=1.
  - Cycle 1 holds stallreq=0 and writes HI/LO on en.
  - A flush in cycle 0 or 1 discards the product.
- EXE_MUL_PIPE_EN undefined: multiply is combinational. HI/LO are written at the end of cycle 0 and stallreq is never raised for multiply.

## Test plan
- Reset with rst_n=0 mid-BUSY, then release → all outputs 0, FSM IDLE, HI=LO=0.
- DIV opr1=7, opr2=0xFFFFFFFE (XLEN=32):
  - stallreq high exactly 33 cycles.
  - Then LO=0xFFFFFFFD, HI=1.
- DIVU 0xFFFFFFFF/0x10 → LO=0x0FFFFFFF, HI=0xF. DIV 5/0 → LO=0xFFFFFFFF, HI=5.
- Multiply 0xFFFFFFFF×2:
  - MULT → HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - MULTU → HI=1, LO=0xFFFFFFFE.
  - MFLO issued the next cycle → ex_wdata_o=0xFFFFFFFE.
  - Run with and without EXE_MUL_PIPE_EN; stallreq is 1 cycle vs 0.
- Flush and stall interactions:
  - ex_flush_i at BUSY cycle 10 → FSM IDLE, stallreq=0, HI/LO unchanged, EX/MEM bubble (wren_o=0).
  - ex_stall_i held 3 cycles in DONE → HI/LO written only on the first edge with en.
